// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider scheduler: FSM encoding, default
// divisor width and a constant clog2 used for index widths.
package clk_div_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STOP = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int clk_div_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/clk_div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward, wrapping
// modulo NREQ, and reports the first pending requester.
module rr_arbiter
    import clk_div_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int OW   = clk_div_clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [OW-1:0]   o_idx,
    output logic            o_valid
);

    int k;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        k       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(i_last) + i) % NREQ;
            if (!o_valid && i_req[k]) begin
                o_valid  = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = OW'(k);
            end
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Schedules divisor changes on one shared even clock divider: hold the divider
// in reset, load the winner's divisor, release, then acknowledge the winner.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = DW_DEF,
    parameter int STALL = 2,
    parameter int OW    = clk_div_clog2(NREQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ*DW-1:0] i_div,
    output logic [NREQ-1:0]  o_ack,
    output logic             o_busy,
    output logic [OW-1:0]    o_owner,
    output logic             o_div_rst,
    output logic [DW-1:0]    o_divisor,
    output state_t           o_state
);

    localparam int CW = clk_div_clog2(STALL) + 1;

    // Handshake: i_req[k] is a level held until o_ack[k] pulses for one cycle;
    // a request still high the cycle after its ack is treated as a new request.
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     div_q, div_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic              div_rst_q, div_rst_d;
    logic [DW-1:0]     divisor_q, divisor_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;

    logic [DW-1:0]     div_arr [NREQ];
    logic [NREQ-1:0]   arb_gnt;
    logic [OW-1:0]     arb_idx;
    logic              arb_valid;
    logic [DW-1:0]     win_div;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign div_arr[g] = i_div[g*DW +: DW];
    end

    // The requester being acked this cycle is masked so its held level is not re-granted.
    rr_arbiter #(.NREQ(NREQ), .OW(OW)) u_arb (
        .i_req   (i_req & ~ack_q),
        .i_last  (owner_q),
        .o_gnt   (arb_gnt),
        .o_idx   (arb_idx),
        .o_valid (arb_valid)
    );

    assign win_div = div_arr[arb_idx];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        owner_d   = owner_q;
        div_rst_d = div_rst_q;
        divisor_d = divisor_q;
        ack_d     = '0;
        case (state_q)
            ST_IDLE: begin
                div_rst_d = 1'b1;
                if (arb_valid) begin
                    owner_d = arb_idx;
                    div_d   = win_div;
                    if (win_div == divisor_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_STOP;
                        div_rst_d = 1'b0;
                        cnt_d     = CW'(STALL - 1);
                    end
                end
            end
            ST_STOP: begin
                div_rst_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d   = ST_LOAD;
                    divisor_d = div_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOAD: begin
                div_rst_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                ack_d[owner_q] = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            owner_q   <= OW'(NREQ - 1);
            div_rst_q <= 1'b0;
            divisor_q <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            owner_q   <= owner_d;
            div_rst_q <= div_rst_d;
            divisor_q <= divisor_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign o_ack     = ack_q;
    assign o_busy    = busy_q;
    assign o_owner   = owner_q;
    assign o_div_rst = div_rst_q;
    assign o_divisor = divisor_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: scenario tasks with inline checks plus an ack
// scoreboard fed when requests are driven and drained when o_ack pulses.
module tb_clk_div_sched;
    import clk_div_pkg::*;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int STALL = 2;
    localparam int OW    = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] div_bus;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic [OW-1:0]     owner;
    logic              div_rst;
    logic [DW-1:0]     divisor;
    state_t            state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [NREQ-1:0] exp_ack_q[$];
    logic [DW-1:0]   exp_div_q[$];

    clk_div_sched #(.NREQ(NREQ), .DW(DW), .STALL(STALL)) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_req     (req),
        .i_div     (div_bus),
        .o_ack     (ack),
        .o_busy    (busy),
        .o_owner   (owner),
        .o_div_rst (div_rst),
        .o_divisor (divisor),
        .o_state   (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic set_div(input int k, input logic [DW-1:0] v);
        div_bus[k*DW +: DW] = v;
    endtask

    task automatic push_exp(input logic [NREQ-1:0] a, input logic [DW-1:0] d);
        exp_ack_q.push_back(a);
        exp_div_q.push_back(d);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        req   = '0;
        rst_n = 1'b0;
        repeat (3) cycle();
        #1 rst_n = 1'b1;
        cycle();
    endtask

    task automatic wait_ack(input int max_cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            cycle();
            if (ack !== '0) begin
                seen = 1'b1;
                req  = req & ~ack;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_timeout: no ack within %0d cycles", name, max_cycles);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [NREQ-1:0] e_ack;
        logic [DW-1:0]   e_div;
        if (rst_n === 1'b1 && ack !== '0) begin
            tests_run++;
            if (exp_ack_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_ack: got ack=%b divisor=%0d, none expected", ack, divisor);
            end else begin
                e_ack = exp_ack_q.pop_front();
                e_div = exp_div_q.pop_front();
                if (ack !== e_ack || divisor !== e_div || div_rst !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL sb_ack: got ack=%b divisor=%0d div_rst=%b, expected ack=%b divisor=%0d div_rst=1",
                             ack, divisor, div_rst, e_ack, e_div);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req     = '0;
        div_bus = '0;
        rst_n   = 1'b0;
        repeat (3) cycle();
        tests_run++;
        if (div_rst !== 1'b0 || divisor !== '0 || ack !== '0 || busy !== 1'b0 ||
            owner !== 2'd3 || state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_values: div_rst=%b divisor=%0d ack=%b busy=%b owner=%0d state=%0d, expected 0 0 0000 0 3 0",
                     div_rst, divisor, ack, busy, owner, state);
        end
        #1 rst_n = 1'b1;
        #1;
        tests_run++;
        if (div_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_hold: div_rst=%b before first edge, expected 0", div_rst);
        end
        cycle();
        tests_run++;
        if (div_rst !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_edge: div_rst=%b busy=%b, expected 1 0", div_rst, busy);
        end
    endtask

    task automatic test_single_change();
        logic            e_rst;
        logic [DW-1:0]   e_divr;
        logic [NREQ-1:0] e_ack;
        set_div(0, 16'd4);
        req = 4'b0001;
        push_exp(4'b0001, 16'd4);
        for (int c = 1; c <= 8; c++) begin
            cycle();
            e_rst  = (c >= 1 && c <= STALL + 1) ? 1'b0 : 1'b1;
            e_divr = (c >= STALL + 1) ? 16'd4 : 16'd0;
            e_ack  = (c == STALL + 3) ? 4'b0001 : 4'b0000;
            tests_run++;
            if (div_rst !== e_rst || divisor !== e_divr || ack !== e_ack) begin
                tests_failed++;
                $display("FAIL single_change_c%0d: div_rst=%b divisor=%0d ack=%b, expected %b %0d %b",
                         c, div_rst, divisor, ack, e_rst, e_divr, e_ack);
            end
            if (c == STALL + 3) req = '0;
        end
    endtask

    task automatic test_equal_divisor();
        logic [NREQ-1:0] e_ack;
        set_div(2, 16'd4);
        req = 4'b0100;
        push_exp(4'b0100, 16'd4);
        for (int c = 1; c <= 4; c++) begin
            cycle();
            e_ack = (c == 2) ? 4'b0100 : 4'b0000;
            tests_run++;
            if (div_rst !== 1'b1 || ack !== e_ack || busy !== (c == 1) || divisor !== 16'd4) begin
                tests_failed++;
                $display("FAIL equal_divisor_c%0d: div_rst=%b ack=%b busy=%b divisor=%0d, expected 1 %b %b 4",
                         c, div_rst, ack, busy, divisor, e_ack, (c == 1));
            end
            if (c == 2) begin
                req = '0;
                tests_run++;
                if (owner !== 2'd2) begin
                    tests_failed++;
                    $display("FAIL equal_divisor_owner: owner=%0d, expected 2", owner);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int acks_seen;
        int busy_bad;
        apply_reset();
        for (int k = 0; k < NREQ; k++) begin
            set_div(k, DW'(5 + k));
            push_exp(NREQ'(1 << k), DW'(5 + k));
        end
        req       = 4'b1111;
        acks_seen = 0;
        busy_bad  = 0;
        for (int c = 0; c < 60 && acks_seen < NREQ; c++) begin
            cycle();
            if (ack !== '0) begin
                acks_seen++;
                req = req & ~ack;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        tests_run++;
        if (acks_seen != NREQ) begin
            tests_failed++;
            $display("FAIL fairness_count: %0d acks seen, expected %0d", acks_seen, NREQ);
        end
        tests_run++;
        if (busy_bad != 0) begin
            tests_failed++;
            $display("FAIL fairness_busy: busy low in %0d non-ack cycles, expected 0", busy_bad);
        end
        tests_run++;
        if (owner !== 2'd3 || divisor !== 16'd8) begin
            tests_failed++;
            $display("FAIL fairness_final: owner=%0d divisor=%0d, expected 3 8", owner, divisor);
        end
    endtask

    task automatic test_zero_divisor();
        set_div(1, 16'd0);
        req = 4'b0010;
        push_exp(4'b0010, 16'd0);
        wait_ack(20, "zero_divisor");
        cycle();
        tests_run++;
        if (divisor !== 16'd0 || div_rst !== 1'b1 || owner !== 2'd1) begin
            tests_failed++;
            $display("FAIL zero_divisor_after: divisor=%0d div_rst=%b owner=%0d, expected 0 1 1",
                     divisor, div_rst, owner);
        end
    endtask

    task automatic test_reset_in_stop();
        set_div(0, 16'd9);
        req = 4'b0001;
        cycle();
        tests_run++;
        if (state !== ST_STOP || div_rst !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_stop_entry: state=%0d div_rst=%b busy=%b, expected 1 0 1", state, div_rst, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (div_rst !== 1'b0 || divisor !== '0 || ack !== '0 || busy !== 1'b0 ||
            owner !== 2'd3 || state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_stop_async: div_rst=%b divisor=%0d ack=%b busy=%b owner=%0d state=%0d, expected 0 0 0000 0 3 0",
                     div_rst, divisor, ack, busy, owner, state);
        end
        cycle();
        cycle();
        tests_run++;
        if (ack !== '0 || state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_stop_held: ack=%b state=%0d, expected 0000 0", ack, state);
        end
        #1 rst_n = 1'b1;
        push_exp(4'b0001, 16'd9);
        wait_ack(20, "reset_stop_reserve");
    endtask

    task automatic test_drop_after_grant();
        logic [NREQ-1:0] e_ack;
        set_div(3, 16'd11);
        req = 4'b1000;
        push_exp(4'b1000, 16'd11);
        cycle();
        req = '0;
        set_div(3, 16'd12);
        for (int c = 2; c <= 7; c++) begin
            cycle();
            e_ack = (c == STALL + 3) ? 4'b1000 : 4'b0000;
            tests_run++;
            if (ack !== e_ack) begin
                tests_failed++;
                $display("FAIL drop_after_grant_c%0d: ack=%b, expected %b", c, ack, e_ack);
            end
        end
        tests_run++;
        if (divisor !== 16'd11 || owner !== 2'd3) begin
            tests_failed++;
            $display("FAIL drop_after_grant_latched: divisor=%0d owner=%0d, expected 11 3", divisor, owner);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_change();
        test_equal_divisor();
        test_fairness();
        test_zero_divisor();
        test_reset_in_stop();
        test_drop_after_grant();
        repeat (4) cycle();
        tests_run++;
        if (exp_ack_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: %0d expected acks never seen, expected 0", exp_ack_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
